mac_vector_unit: RTL and testbench
==================================

// Module: mac_vector_unit
// PURPOSE
//  Parametrised successor to the scalar MAC: LANES signed weight*input products per beat,
//  pipelined adder-tree reduction into one wide accumulator over a programmable vector length.
//  Adds bias, optional ReLU, arithmetic output shift and saturation, with valid/ready handshakes.
//  Sits between the weight/activation buffers and the layer output writer; one neuron per op.
// PARAMETERS
//  LANES      4   products reduced per beat (power of two, >=1)
//  DATA_WIDTH 8   signed width of each weight and input element (`DATA_WIDTH in defines.vh)
//  ACC_WIDTH  32  signed accumulator width (`ACC_WIDTH); >= 2*DATA_WIDTH+log2(LANES)
//  OUT_WIDTH  8   signed width of the post-processed output
//  OUT_SHIFT  0   arithmetic right shift applied before saturation (truncate toward -inf)
//  CNT_WIDTH  16  width of the beat counter / vec_len
// PORTS
//  clk          in  1                 clock, all state on rising edge
//  reset_n      in  1                 asynchronous, active-low reset
//  start        in  1                 begin op; accepted only in IDLE
//  abort        in  1                 synchronous abort, returns to IDLE
//  vec_len      in  CNT_WIDTH         beats in op, sampled at start
//  bias         in  ACC_WIDTH signed  sampled at start
//  relu_en      in  1                 sampled at start
//  in_valid     in  1                 beat valid
//  in_ready     out 1                 high iff state==ACCUM
//  weight_vec   in  LANES*DATA_WIDTH  lane i = bits [i*DATA_WIDTH +: DATA_WIDTH], signed
//  input_vec    in  LANES*DATA_WIDTH  same packing
//  out_valid    out 1                 result held until out_ready
//  out_ready    in  1                 consumer ready
//  out_data     out OUT_WIDTH signed  post-processed result
//  acc_result   out ACC_WIDTH signed  raw accumulator (pre-bias)
//  sat_flag     out 1                 out_data was clamped; valid with out_valid
//  busy         out 1                 state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; accumulator, pipeline regs, beat count, out_data, acc_result, sat_flag,
//   out_valid, in_ready, busy all 0. Reset mid-op discards the op entirely.
//  FSM IDLE -> ACCUM (start, vec_len!=0) | DRAIN (start, vec_len==0); start clears accumulator.
//   ACCUM: beat accepted on in_valid&in_ready; after vec_len-th beat -> DRAIN.
//   DRAIN: exactly 2 cycles (flush S1/S2), then out register loaded -> OUT.
//   OUT: out_valid=1; out_valid&out_ready -> IDLE, out_valid drops next cycle.
//   abort in any non-IDLE state -> IDLE next edge; out_valid and sat_flag cleared. Pipeline
//   contents are discarded (next start clears accumulator). abort beats start.
//  start outside IDLE is ignored; vec_len/bias/relu_en changes after start are ignored.
//  Pipeline: S1 registers LANES full-width signed products of the accepted beat (with a valid bit);
//   S2 adds the sign-extended tree sum to the accumulator. No bubble penalty: in_valid gaps
//   only delay, never change, the result.
//  Latency: last beat accepted at edge E -> out_valid high after edge E+3.
//   vec_len==0: start at edge E -> out_valid after edge E+2, result = f(bias).
//  Accumulator wraps modulo 2^ACC_WIDTH (no saturation inside the accumulation).
//  Post-process (ACC_WIDTH+1 bits): s = acc + bias; if relu_en and s<0 then s=0; s >>>= OUT_SHIFT;
//   clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; sat_flag=1 iff clamped.
//  out_data/acc_result/sat_flag are stable while out_valid=1 and out_ready=0.
// STRUCTURE
//  Shared defines (defines.vh): DATA_WIDTH, ACC_WIDTH, FSM state encodings (IDLE/ACCUM/DRAIN/OUT).
//  One sub-module: mac_adder_tree (combinational, LANES signed inputs -> log2 growth sum),
//   instantiated between S1 and S2. FSM, counter and post-process stay in this module.
// TESTING (LANES=4, DATA_WIDTH=8, ACC_WIDTH=32, OUT_WIDTH=8, OUT_SHIFT=0)
//  vec_len=2, w all 1, in {1,2,3,4},{5,6,7,8}, bias 0 -> acc_result 36, out_data 36, out_valid at E+3.
//  vec_len=1, w all -128, in all 127, relu off -> acc -65024, out_data -128, sat_flag=1;
//   repeat with relu_en=1 -> out_data 0, sat_flag=0.
//  vec_len=0, bias 100 -> out_data 100 after E+2; bias 300 -> out_data 127, sat_flag=1.
//  vec_len=4 with in_valid toggling every other cycle -> same result as back-to-back beats.
//  out_ready low 5 cycles in OUT -> outputs stable, in_ready=0, start ignored; release -> IDLE.
//  abort in ACCUM after 2 beats, then reset_n low mid-op -> all outputs 0; next op with the
//   first test's stimulus yields 36 exactly.

Source files
------------

// File: rtl/mac_vector_unit_pkg.sv
// Shared types for the vector MAC: FSM state encoding used by the top level.
package mac_vector_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/mac_adder_tree.sv
// Combinational balanced adder tree: LANES signed terms reduced to one sum that grows
// by log2(LANES) bits, so the reduction can never overflow.
module mac_adder_tree #(
  parameter int LANES    = 4,
  parameter int IN_WIDTH = 16
) (
  input  logic [LANES*IN_WIDTH-1:0]                 terms,
  output logic signed [IN_WIDTH+$clog2(LANES)-1:0]  sum
);

  localparam int LEVELS = $clog2(LANES);
  localparam int SUM_W  = IN_WIDTH + LEVELS;

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    logic signed [SUM_W-1:0] node [LANES >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < LANES; i++) begin : g_in
        assign node[i] = SUM_W'($signed(terms[i*IN_WIDTH +: IN_WIDTH]));
      end
    end else begin : g_add
      for (genvar i = 0; i < (LANES >> l); i++) begin : g_pair
        assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
      end
    end
  end

  assign sum = g_lvl[LEVELS].node[0];

endmodule

// File: rtl/mac_vector_unit.sv
// Vector MAC: LANES products per beat, S1 product register, adder tree, S2 accumulator,
// then bias / ReLU / shift / saturate into a held output with valid/ready handshakes.
module mac_vector_unit
  import mac_vector_unit_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int OUT_SHIFT  = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [CNT_WIDTH-1:0]          vec_len,
  input  logic signed [ACC_WIDTH-1:0]   bias,
  input  logic                          relu_en,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   weight_vec,
  input  logic [LANES*DATA_WIDTH-1:0]   input_vec,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic signed [ACC_WIDTH-1:0]   acc_result,
  output logic                          sat_flag,
  output logic                          busy
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int TREE_W = PROD_W + $clog2(LANES);
  localparam int SUM_W  = ACC_WIDTH + 1;
  localparam logic signed [SUM_W-1:0] OUT_MAX =
    {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] OUT_MIN = ~OUT_MAX;

  state_t                      state, state_next;
  logic [CNT_WIDTH-1:0]        beat_cnt, len_q;
  logic signed [ACC_WIDTH-1:0] bias_q, acc;
  logic                        relu_q;
  logic [LANES*PROD_W-1:0]     prod, s1_prod;
  logic                        s1_valid, drain_cnt;
  logic signed [TREE_W-1:0]    tree_sum;
  logic                        start_acc, beat, last_beat, drain_done, load_out;
  logic signed [SUM_W-1:0]     pp_sum, pp_relu, pp_shift;
  logic [OUT_WIDTH-1:0]        pp_out;
  logic                        pp_sat;

  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_OUT);
  assign busy      = (state != ST_IDLE);

  // Abort wins over both start and an in-flight beat.
  assign start_acc  = (state == ST_IDLE) && start && !abort;
  assign beat       = in_valid && in_ready && !abort;
  assign last_beat  = beat && (beat_cnt == len_q - CNT_WIDTH'(1));
  // DRAIN counts its two cycles only once S1 is empty, so the last product is in acc.
  assign drain_done = (state == ST_DRAIN) && !s1_valid && drain_cnt;
  assign load_out   = drain_done && !abort;

  always_comb begin
    prod = '0;
    for (int i = 0; i < LANES; i++) begin
      prod[i*PROD_W +: PROD_W] = PROD_W'($signed(weight_vec[i*DATA_WIDTH +: DATA_WIDTH]))
                               * PROD_W'($signed(input_vec[i*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  mac_adder_tree #(
    .LANES    (LANES),
    .IN_WIDTH (PROD_W)
  ) u_tree (
    .terms (s1_prod),
    .sum   (tree_sum)
  );

  // NOTE: every variable gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start_acc) state_next = (vec_len == '0) ? ST_DRAIN : ST_ACCUM;
      ST_ACCUM: if (last_beat) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_next = ST_OUT;
      ST_OUT:   if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE) state_next = ST_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    pp_sum   = SUM_W'(acc) + SUM_W'(bias_q);
    pp_relu  = (relu_q && pp_sum[SUM_W-1]) ? '0 : pp_sum;
    pp_shift = pp_relu >>> OUT_SHIFT;
    pp_sat   = 1'b0;
    pp_out   = pp_shift[OUT_WIDTH-1:0];
    if (pp_shift > OUT_MAX) begin
      pp_out = OUT_MAX[OUT_WIDTH-1:0];
      pp_sat = 1'b1;
    end else if (pp_shift < OUT_MIN) begin
      pp_out = OUT_MIN[OUT_WIDTH-1:0];
      pp_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt   <= '0;
      len_q      <= '0;
      bias_q     <= '0;
      relu_q     <= 1'b0;
      s1_prod    <= '0;
      s1_valid   <= 1'b0;
      drain_cnt  <= 1'b0;
      acc        <= '0;
      out_data   <= '0;
      acc_result <= '0;
      sat_flag   <= 1'b0;
    end else begin
      if (start_acc) begin
        len_q    <= vec_len;
        bias_q   <= bias;
        relu_q   <= relu_en;
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + CNT_WIDTH'(1);
      end

      s1_valid <= beat;
      if (beat) s1_prod <= prod;

      // Accumulation wraps modulo 2^ACC_WIDTH by design.
      if (start_acc)     acc <= '0;
      else if (s1_valid) acc <= acc + ACC_WIDTH'(tree_sum);

      drain_cnt <= (state == ST_DRAIN && !s1_valid && !abort) ? !drain_cnt : 1'b0;

      if (load_out) begin
        out_data   <= pp_out;
        acc_result <= acc;
        sat_flag   <= pp_sat;
      end else if (abort && state != ST_IDLE) begin
        sat_flag   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_vector_unit.sv
// Self-checking bench for mac_vector_unit: directed and randomised neuron ops compared
// against a plain-arithmetic reference model of dot product, bias, ReLU, shift and clamp.
module tb_mac_vector_unit;

  localparam int LANES = 4, DW = 8, AW = 32, OW = 8, OUT_SHIFT = 0, CW = 16;

  logic                 clk = 1'b0;
  logic                 reset_n, start, abort, relu_en, in_valid, out_ready;
  logic [CW-1:0]        vec_len;
  logic signed [AW-1:0] bias;
  logic [LANES*DW-1:0]  weight_vec, input_vec;
  logic                 in_ready, out_valid, sat_flag, busy;
  logic signed [OW-1:0] out_data;
  logic signed [AW-1:0] acc_result;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0]          wq[$], xq[$];
  logic signed [AW-1:0] exp_acc;
  logic signed [OW-1:0] exp_out;
  logic                 exp_sat;

  mac_vector_unit #(
    .LANES(LANES), .DATA_WIDTH(DW), .ACC_WIDTH(AW),
    .OUT_WIDTH(OW), .OUT_SHIFT(OUT_SHIFT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .vec_len(vec_len), .bias(bias), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready),
    .weight_vec(weight_vec), .input_vec(input_vec),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .acc_result(acc_result),
    .sat_flag(sat_flag), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: signed dot product summed over beats, wrapped to AW bits, then post-processed.
  task automatic model(input int len, input longint b, input logic r);
    longint acc_l, s;
    logic [31:0] tw, tx;
    logic signed [DW-1:0] wv, xv;
    acc_l = 0;
    for (int k = 0; k < len; k++) begin
      tw = wq[k];
      tx = xq[k];
      for (int i = 0; i < LANES; i++) begin
        wv = tw[i*DW +: DW];
        xv = tx[i*DW +: DW];
        acc_l += longint'(wv) * longint'(xv);
      end
    end
    exp_acc = acc_l[AW-1:0];
    s = longint'(exp_acc) + b;
    if (r && s < 0) s = 0;
    s = s >>> OUT_SHIFT;
    exp_sat = 1'b1;
    if (s > 127)       exp_out = 8'sd127;
    else if (s < -128) exp_out = -8'sd128;
    else begin
      exp_out = s[OW-1:0];
      exp_sat = 1'b0;
    end
  endtask

  // gap_mode: 0 back-to-back, 1 in_valid every other cycle, 2 random gaps.
  task automatic run_op(input int len, input int b, input logic r, input int gap_mode,
                        input int hold, input string name);
    int idx, guard, n, e_start, e_last, ref_e, exp_lat;
    logic v, acc;
    model(len, longint'(b), r);
    vec_len = CW'(len); bias = b; relu_en = r; start = 1'b1;
    tick();
    start = 1'b0;
    e_start = cyc;
    e_last = cyc;
    vec_len = CW'($urandom); bias = $urandom; relu_en = ~r;
    idx = 0; guard = 0;
    while (idx < len && guard < 500) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = 1'($urandom % 2);
      endcase
      in_valid = v; weight_vec = wq[idx]; input_vec = xq[idx];
      acc = v && in_ready;
      tick();
      guard++;
      if (acc) begin
        idx++;
        e_last = cyc;
      end
    end
    in_valid = 1'b0; weight_vec = $urandom; input_vec = $urandom;
    n_checks++;
    if (idx != len) begin
      n_fail++;
      $display("FAIL %s beats: accepted %0d required %0d", name, idx, len);
    end
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL %s out_valid timeout: got 0 required 1", name);
    end else begin
      ref_e   = (len == 0) ? e_start : e_last;
      exp_lat = (len == 0) ? 2 : 3;
      n_checks++;
      if (cyc - ref_e != exp_lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d required %0d", name, cyc - ref_e, exp_lat);
      end
    end
    n_checks++;
    if (out_data !== exp_out) begin
      n_fail++;
      $display("FAIL %s out_data: got %0d required %0d", name, out_data, exp_out);
    end
    n_checks++;
    if (acc_result !== exp_acc) begin
      n_fail++;
      $display("FAIL %s acc_result: got %0d required %0d", name, acc_result, exp_acc);
    end
    n_checks++;
    if (sat_flag !== exp_sat || in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s sat/in_ready/busy: got %b%b%b required %b01", name,
               sat_flag, in_ready, busy, exp_sat);
    end
    for (int h = 0; h < hold; h++) begin
      start = 1'b1; vec_len = 16'd1;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_out ||
          acc_result !== exp_acc || sat_flag !== exp_sat) begin
        n_fail++;
        $display("FAIL %s hold %0d: got v=%b rdy=%b out=%0d acc=%0d sat=%b required v=1 rdy=0 out=%0d acc=%0d sat=%b",
                 name, h, out_valid, in_ready, out_data, acc_result, sat_flag,
                 exp_out, exp_acc, exp_sat);
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release: got out_valid=%b busy=%b required 0 0", name, out_valid, busy);
    end
  endtask

  task automatic load_basic();
    wq = '{32'h01010101, 32'h01010101};
    xq = '{32'h04030201, 32'h08070605};
  endtask

  task automatic load_random(input int len);
    wq.delete(); xq.delete();
    for (int k = 0; k < len; k++) begin
      wq.push_back($urandom);
      xq.push_back($urandom);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || sat_flag !== 1'b0 ||
        out_data !== '0 || acc_result !== '0) begin
      n_fail++;
      $display("FAIL %s: got v=%b rdy=%b busy=%b sat=%b out=%0d acc=%0d required all 0",
               name, out_valid, in_ready, busy, sat_flag, out_data, acc_result);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0; abort = 1'b0; relu_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    vec_len = '0; bias = '0; weight_vec = '0; input_vec = '0;
    repeat (3) tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();
    check_all_zero("post-reset idle");
  endtask

  task automatic test_basic();
    load_basic();
    run_op(2, 0, 1'b0, 0, 0, "basic");
    n_checks++;
    if (acc_result !== 32'sd36) begin
      n_fail++;
      $display("FAIL basic const: got %0d required 36", acc_result);
    end
  endtask

  task automatic test_saturation();
    wq = '{32'h80808080};
    xq = '{32'h7f7f7f7f};
    run_op(1, 0, 1'b0, 0, 0, "sat relu off");
    run_op(1, 0, 1'b1, 0, 0, "sat relu on");
  endtask

  task automatic test_zero_len();
    wq.delete(); xq.delete();
    run_op(0, 100, 1'b0, 0, 0, "zero len bias 100");
    run_op(0, 300, 1'b0, 0, 0, "zero len bias 300");
  endtask

  task automatic test_abort_reset();
    abort = 1'b1; start = 1'b1; vec_len = 16'd2;
    tick();
    abort = 1'b0; start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort beats start: got busy=%b required 0", busy);
    end
    load_basic();
    vec_len = 16'd4; bias = '0; relu_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; weight_vec = wq[k]; input_vec = xq[k];
      tick();
    end
    in_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || sat_flag !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: got busy=%b v=%b sat=%b rdy=%b required 0000",
               busy, out_valid, sat_flag, in_ready);
    end
    vec_len = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; weight_vec = wq[0]; input_vec = xq[0];
    tick();
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_all_zero("reset mid-op");
    tick();
    reset_n = 1'b1;
    tick();
    load_basic();
    run_op(2, 0, 1'b0, 0, 0, "after abort/reset");
    n_checks++;
    if (acc_result !== 32'sd36 || out_data !== 8'sd36) begin
      n_fail++;
      $display("FAIL after abort/reset const: got acc=%0d out=%0d required 36 36",
               acc_result, out_data);
    end
  endtask

  task automatic test_gaps();
    load_random(4);
    run_op(4, 10, 1'b0, 1, 0, "gaps toggle");
    run_op(4, 10, 1'b0, 0, 0, "gaps back-to-back");
  endtask

  task automatic test_backpressure();
    load_basic();
    run_op(2, -50, 1'b0, 0, 5, "backpressure");
  endtask

  task automatic test_random();
    int len;
    for (int t = 0; t < 8; t++) begin
      len = int'($urandom_range(0, 6));
      load_random(len);
      run_op(len, int'($urandom_range(0, 600)) - 300, 1'($urandom % 2), 2,
             int'($urandom_range(0, 2)), "random");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_zero_len();
    test_abort_reset();
    test_gaps();
    test_backpressure();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
